sseg_serial_tx: RTL and testbench

Parallel-to-serial transmitter for the on-board 8-digit seven-segment display chain. It takes the 64-bit segment-ordered word that the segment bit-order mapper produces and shifts it into the external shift-register chain. It generates the serial clock, the data line and the latch strobe. It sits between the segment mapper and the board pins, and the display refresh controller triggers it with a one-cycle start.

---
 rtl/sseg_pkg.sv | 14 +
 rtl/sseg_bit_tick.sv | 26 ++
 rtl/sseg_serial_tx.sv | 140 ++++++++++++++
 tb/tb_sseg_serial_tx.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared constants and state encoding for the seven-segment serial display chain.
package sseg_pkg;

    localparam int SSEG_DATA_W  = 64;
    localparam int SSEG_CLK_DIV = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2,
        ST_DONE  = 2'd3
    } sseg_state_e;

endpackage

// File: rtl/sseg_bit_tick.sv
// Free-running divider that emits a one-cycle tick every CLK_DIV enabled clocks.
module sseg_bit_tick #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [7:0] TERM = 8'(CLK_DIV - 1);

    logic [7:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= (cnt_reg == TERM) ? 8'd0 : cnt_reg + 8'd1;
        end
    end

    assign tick = en && (cnt_reg == TERM);

endmodule

// File: rtl/sseg_serial_tx.sv
// Shifts a 64-bit segment frame MSB first into the external display chain,
// generating seg_clk, seg_sout and the seg_pen latch strobe.
module sseg_serial_tx
    import sseg_pkg::*;
#(
    parameter int DATA_W  = SSEG_DATA_W,
    parameter int CLK_DIV = SSEG_CLK_DIV
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] par_data,
    output logic              seg_clk,
    output logic              seg_sout,
    output logic              seg_pen,
    output logic              seg_clrn,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] S_IDLE  = 2'(ST_IDLE);
    localparam logic [1:0] S_SHIFT = 2'(ST_SHIFT);
    localparam logic [1:0] S_LATCH = 2'(ST_LATCH);
    localparam logic [1:0] S_DONE  = 2'(ST_DONE);

    logic [1:0]        state_reg, state_next;
    logic [DATA_W-1:0] shift_reg, shift_next, shifted;
    logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
    logic              seg_clk_reg, seg_clk_next;
    logic              seg_pen_reg, seg_pen_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              seg_clrn_reg;
    logic              accept, tick_en, tick;

    assign accept  = (state_reg == S_IDLE) && start;
    assign tick_en = (state_reg == S_SHIFT) || (state_reg == S_LATCH);

    sseg_bit_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_bit_tick (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .en  (tick_en),
        .tick(tick)
    );

    // Left shift with zero fill; after the final bit the register is all zero,
    // which is what drives seg_sout low once the frame leaves SHIFT.
    assign shifted[0] = 1'b0;
    for (genvar gi = 1; gi < DATA_W; gi++) begin : g_shift
        assign shifted[gi] = shift_reg[gi-1];
    end

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        seg_clk_next = seg_clk_reg;
        seg_pen_next = seg_pen_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next   = S_SHIFT;
                    shift_next   = par_data;
                    bit_cnt_next = '0;
                    seg_clk_next = 1'b0;
                    busy_next    = 1'b1;
                end
            end
            S_SHIFT: begin
                if (tick) begin
                    seg_clk_next = ~seg_clk_reg;
                    // Falling toggle: the chain has taken the current bit.
                    if (seg_clk_reg) begin
                        shift_next   = shifted;
                        bit_cnt_next = bit_cnt_reg + CNT_ONE;
                        if (bit_cnt_reg == LAST_BIT) begin
                            state_next   = S_LATCH;
                            seg_pen_next = 1'b1;
                        end
                    end
                end
            end
            S_LATCH: begin
                if (tick) begin
                    state_next   = S_DONE;
                    seg_pen_next = 1'b0;
                    done_next    = 1'b1;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
                busy_next  = 1'b0;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            seg_clk_reg <= 1'b0;
            seg_pen_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            seg_clk_reg <= seg_clk_next;
            seg_pen_reg <= seg_pen_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    always_ff @(posedge clk) begin
        seg_clrn_reg <= ~rst;
    end

    assign seg_clk  = seg_clk_reg;
    assign seg_sout = shift_reg[DATA_W-1];
    assign seg_pen  = seg_pen_reg;
    assign seg_clrn = seg_clrn_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_sseg_serial_tx.sv
// Checks two transmitters (CLK_DIV=2 and CLK_DIV=1) against a timeline model
// derived from the frame timing rules, plus hand-computed cycle expectations.
module tb_sseg_serial_tx;

    localparam int DW = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic [1:0]    start_v = 2'b00;
    logic [DW-1:0] par_v [2];
    logic [1:0]    sclk, ssout, spen, sclrn, sbusy, sdone;

    sseg_serial_tx #(.DATA_W(DW), .CLK_DIV(2)) dut_d2 (
        .clk(clk), .rst(rst), .start(start_v[0]), .par_data(par_v[0]),
        .seg_clk(sclk[0]), .seg_sout(ssout[0]), .seg_pen(spen[0]),
        .seg_clrn(sclrn[0]), .busy(sbusy[0]), .done(sdone[0])
    );

    sseg_serial_tx #(.DATA_W(DW), .CLK_DIV(1)) dut_d1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .par_data(par_v[1]),
        .seg_clk(sclk[1]), .seg_sout(ssout[1]), .seg_pen(spen[1]),
        .seg_clrn(sclrn[1]), .busy(sbusy[1]), .done(sdone[1])
    );

    // Timeline model: a frame accepted at cycle t0 fully determines every
    // output at cycle t0+t through plain arithmetic on t.
    int            cyc = 0;
    logic          m_active [2] = '{1'b0, 1'b0};
    int            m_t0 [2] = '{0, 0};
    logic [DW-1:0] m_frame [2];
    logic          m_rst_q = 1'b1;

    function automatic int div_of(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic int done_t(input int i);
        return 2 * div_of(i) * DW + div_of(i) + 1;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_active[i] <= 1'b0;
            end else if (start_v[i] && !(m_active[i] && (cyc - m_t0[i]) <= done_t(i))) begin
                m_active[i] <= 1'b1;
                m_t0[i]     <= cyc;
                m_frame[i]  <= par_v[i];
            end
        end
        m_rst_q <= rst;
        cyc     <= cyc + 1;
    end

    // {seg_clk, seg_sout, seg_pen, seg_clrn, busy, done}
    function automatic logic [5:0] exp_vec(input int i, input int c);
        int d, t, k, sh;
        logic ck, so, pe, bu, dn;
        d = div_of(i);
        sh = 2 * d * DW;
        ck = 1'b0; so = 1'b0; pe = 1'b0; bu = 1'b0; dn = 1'b0;
        if (m_active[i]) begin
            t = c - m_t0[i];
            if (t >= 1 && t <= sh) begin
                k  = (t - 1) / (2 * d);
                so = m_frame[i][DW-1-k];
                ck = ((t - 1) % (2 * d)) >= d;
                bu = 1'b1;
            end else if (t > sh && t <= sh + d) begin
                pe = 1'b1;
                bu = 1'b1;
            end else if (t == sh + d + 1) begin
                dn = 1'b1;
                bu = 1'b1;
            end
        end
        return {ck, so, pe, ~m_rst_q, bu, dn};
    endfunction

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic [1:0]    prev_clk = 2'b00;
    logic [DW-1:0] cap [2];
    int            rises [2] = '{0, 0};

    task automatic compare_cycle();
        for (int i = 0; i < 2; i++) begin
            logic [5:0] act_v;
            int t;
            act_v = {sclk[i], ssout[i], spen[i], sclrn[i], sbusy[i], sdone[i]};
            check($sformatf("model_dut%0d", i), {58'd0, act_v}, {58'd0, exp_vec(i, cyc)});
            t = cyc - m_t0[i];
            if (m_active[i] && t == 1) begin
                cap[i]   = '0;
                rises[i] = 0;
            end
            if (sclk[i] && !prev_clk[i]) begin
                cap[i] = {cap[i][DW-2:0], ssout[i]};
                rises[i]++;
            end
            prev_clk[i] = sclk[i];
            if (m_active[i] && t == done_t(i)) begin
                check($sformatf("rises_dut%0d", i), 64'(rises[i]), 64'(DW));
                check($sformatf("capture_dut%0d", i), cap[i], m_frame[i]);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_cycle();
    endtask

    localparam logic [DW-1:0] FRAME_A = 64'h8000_0000_0000_0001;
    localparam logic [DW-1:0] FRAME_B = 64'hA5A5_5A5A_FFFF_0000;
    localparam logic [DW-1:0] FRAME_1 = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        int s;
        int dones;
        par_v[0] = '0;
        par_v[1] = '0;

        // Reset held for cycles 0..2.
        tick();
        check("rst_clrn", {63'd0, sclrn[0]}, 64'd0);
        tick();
        tick();
        rst = 1'b0;
        check("rst_out_d2", {58'd0, sclk[0], ssout[0], spen[0], sclrn[0], sbusy[0], sdone[0]}, 64'd0);
        tick();
        check("clrn_after_rst", {62'd0, sclrn}, 64'd3);
        repeat (10) tick();
        check("idle_no_clk", 64'(rises[0] + rises[1]), 64'd0);

        // Frame A on D=2 with busy-time starts, all-ones on D=1, frame B back-to-back.
        s = cyc;
        dones = 0;
        for (int c = 0; c <= 260; c++) begin
            if (c > 0) tick();
            if (c <= 259 && sdone[0]) dones++;
            case (c)
                1:   begin check("a_bit0_sout", {63'd0, ssout[0]}, 64'd1);
                           check("a_bit0_clk", {63'd0, sclk[0]}, 64'd0);
                           check("a_busy", {63'd0, sbusy[0]}, 64'd1);
                           check("o_bit0_sout", {63'd0, ssout[1]}, 64'd1); end
                2:   check("o_clk_rise", {63'd0, sclk[1]}, 64'd1);
                3:   check("a_clk_rise", {63'd0, sclk[0]}, 64'd1);
                4:   check("a_bit0_hold", {63'd0, ssout[0]}, 64'd1);
                5:   check("a_bit1_sout", {63'd0, ssout[0]}, 64'd0);
                128: check("o_last_bit", {63'd0, ssout[1]}, 64'd1);
                129: begin check("o_pen", {63'd0, spen[1]}, 64'd1);
                           check("o_sout_low", {63'd0, ssout[1]}, 64'd0); end
                130: check("o_done", {63'd0, sdone[1]}, 64'd1);
                253: check("a_bit63_start", {63'd0, ssout[0]}, 64'd1);
                256: check("a_bit63_end", {63'd0, ssout[0]}, 64'd1);
                257: begin check("a_pen_257", {63'd0, spen[0]}, 64'd1);
                           check("a_sout_257", {63'd0, ssout[0]}, 64'd0); end
                258: check("a_pen_258", {63'd0, spen[0]}, 64'd1);
                259: begin check("a_done", {63'd0, sdone[0]}, 64'd1);
                           check("a_pen_off", {63'd0, spen[0]}, 64'd0); end
                260: check("a_idle_busy", {63'd0, sbusy[0]}, 64'd0);
                default: ;
            endcase
            start_v[0] = (c == 0 || c == 10 || c == 100 || c == 259 || c == 260);
            par_v[0]   = (c == 0) ? FRAME_A : (c == 260) ? FRAME_B : {$urandom, $urandom};
            start_v[1] = (c == 0);
            par_v[1]   = (c == 0) ? FRAME_1 : {$urandom, $urandom};
        end
        check("a_done_once", 64'(dones), 64'd1);
        tick();
        start_v = 2'b00;
        check("b_busy", {63'd0, sbusy[0]}, 64'd1);
        repeat (265) tick();

        // Reset in the middle of a frame.
        s = cyc;
        start_v[0] = 1'b1;
        par_v[0]   = {$urandom, $urandom};
        for (int c = 1; c <= 120; c++) begin
            tick();
            start_v[0] = 1'b0;
        end
        rst = 1'b1;
        tick();
        check("mid_rst_out", {58'd0, sclk[0], ssout[0], spen[0], sclrn[0], sbusy[0], sdone[0]}, 64'd0);
        rst = 1'b0;
        repeat (5) tick();
        start_v[0] = 1'b1;
        par_v[0]   = {$urandom, $urandom};
        tick();
        start_v[0] = 1'b0;
        repeat (265) tick();

        // Randomized traffic, including occasional resets.
        for (int n = 0; n < 6000; n++) begin
            tick();
            start_v[0] = ($urandom_range(0, 99) < 2);
            par_v[0]   = {$urandom, $urandom};
            start_v[1] = ($urandom_range(0, 99) < 3);
            par_v[1]   = {$urandom, $urandom};
            rst        = ($urandom_range(0, 1499) == 0);
        end
        start_v = 2'b00;
        rst = 1'b0;
        repeat (300) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
